debouncer: RTL
==============

DEBOUNCER -- requirements
Module: debouncer

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 500000, the number of consecutive identical samples required to accept a new level (10 ms at 50 MHz).
REQ-002 SHALL have port clk  input  1  system clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port in  input  1  raw asynchronous switch or button level.
REQ-005 SHALL have port out  output  1  debounced level, registered, driving the downstream dual-edge detector's in.

Function
REQ-006 SHALL derive s_in, the sampled input, from in via the input stage defined under Configuration.
REQ-007 SHALL implement an FSM with states STABLE_LO, WAIT_HI, STABLE_HI and WAIT_LO; out = 1 only in STABLE_HI and WAIT_LO.
REQ-008 STABLE_LO: if s_in=1, SHALL go to WAIT_HI with cnt <= 1; otherwise SHALL hold with cnt <= 0.
REQ-009 WAIT_HI: if s_in=0, SHALL return to STABLE_LO with cnt <= 0; else if cnt = DEBOUNCE_CYCLES-1, SHALL go to STABLE_HI with cnt <= 0; else SHALL set cnt <= cnt+1.
REQ-010 STABLE_HI and WAIT_LO SHALL mirror REQ-008 and REQ-009 with the polarity of s_in inverted.
REQ-011 out SHALL be a register updated on the same edge as the state transition, with no combinational path from in to out.
REQ-012 cnt width SHALL be $clog2(DEBOUNCE_CYCLES+1); cnt SHALL never exceed DEBOUNCE_CYCLES-1 and SHALL never wrap.
REQ-013 A level change SHALL be accepted only after exactly DEBOUNCE_CYCLES consecutive samples of the new level; any opposite sample SHALL discard the partial count.
REQ-014 Latency: in changes before edge k and then stays stable; out SHALL change immediately after edge k+DEBOUNCE_CYCLES+1 (sync enabled) or after edge k+DEBOUNCE_CYCLES (sync disabled).
REQ-015 A pulse on in shorter than DEBOUNCE_CYCLES samples SHALL produce no change on out.
REQ-016 A pulse of exactly DEBOUNCE_CYCLES samples SHALL be accepted.
REQ-017 DEBOUNCE_CYCLES < 2 SHALL be rejected at elaboration with $error.

Reset
REQ-018 While rst=1 at a clock edge, the block SHALL set state = STABLE_LO, cnt = 0, out = 0 and all input-stage flops = 0.
REQ-019 rst SHALL take priority over every transition, including mid-count in WAIT_HI or WAIT_LO.
REQ-020 After rst deasserts with in=1, the block SHALL qualify the high level per REQ-014 as a fresh change.

Configuration
REQ-021 Macro DEBOUNCE_SYNC_EN defined: s_in SHALL be the output of a two-flop synchronizer on in, adding 1 cycle over the undefined case.
REQ-022 Macro DEBOUNCE_SYNC_EN undefined: s_in SHALL be a single register of in.
REQ-023 All other behaviour SHALL be identical with and without DEBOUNCE_SYNC_EN.

Verification (DEBOUNCE_CYCLES=4, 20 ns clk, DEBOUNCE_SYNC_EN defined unless noted)
REQ-024 rst=1 for 2 cycles with in=1 -> out=0 throughout reset; out rises 5 edges after the first post-reset edge.
REQ-025 in 0->1 before edge k, held -> out=0 through edge k+4, out=1 after edge k+5; remains 1 while in=1.
REQ-026 Bounce 1,0,1,1,0 (one value per cycle), then in=1 held -> out rises only 4 samples after the final 0->1 transition.
REQ-027 Glitch: in=1 for 3 cycles, then 0 -> out stays 0; in=1 for exactly 4 cycles -> out pulses high for 4 cycles, lagging in by 5 cycles.
REQ-028 rst asserted while in WAIT_LO with cnt=2 -> next edge: out=0, state STABLE_LO, cnt=0.
REQ-029 Build without DEBOUNCE_SYNC_EN and repeat REQ-025 -> out=1 after edge k+4.

Source files
------------

// File: rtl/debouncer.sv
// -----------------------------------------------------------------------------
// debouncer
//
// Purpose:
//   Filters a bouncing switch/button level. A new level is accepted only after
//   DEBOUNCE_CYCLES consecutive samples of that level. Any opposite sample
//   discards the partial count.
//
//   The input stage is selected by the macro DEBOUNCE_SYNC_EN:
//     defined   : two-flop synchronizer on `in` (one extra cycle of latency)
//     undefined : a single register on `in`
//
// Parameters:
//   DEBOUNCE_CYCLES : number of consecutive identical samples needed to accept
//                     a new level (default 500000, i.e. 10 ms at 50 MHz); >= 2
//
// Ports:
//   clk : system clock; all state updates on the rising edge
//   rst : synchronous, active-high reset
//   in  : raw asynchronous switch/button level
//   out : debounced level, registered
//
// Handshake: none. `in` is a free-running level and `out` is a level that is
// valid on every cycle. There is no valid/ready pair.
//
// Debug visibility:
//   state_q holds the FSM state. Encoding: STABLE_LO=0, WAIT_HI=1,
//   STABLE_HI=2, WAIT_LO=3. cnt_q holds the run-length counter.
// -----------------------------------------------------------------------------
module debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic out
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  generate
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_cycles
      $error("debouncer: DEBOUNCE_CYCLES must be at least 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    WAIT_HI   = 2'd1,
    STABLE_HI = 2'd2,
    WAIT_LO   = 2'd3
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_d;
  logic            out_d;
  logic            s_in;

  // ---------------------------------------------------------------------------
  // Input stage
  // ---------------------------------------------------------------------------
`ifdef DEBOUNCE_SYNC_EN
  logic sync_meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_meta <= 1'b0;
      s_in      <= 1'b0;
    end else begin
      sync_meta <= in;
      s_in      <= sync_meta;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      s_in <= 1'b0;
    end else begin
      s_in <= in;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // FSM state, counter and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= STABLE_LO;
      cnt_q   <= '0;
      out     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out     <= out_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // The first sample of the new level already counts as sample #1. That is why
  // entering a WAIT state loads 1, and the transition fires when cnt_q reaches
  // DEBOUNCE_CYCLES-1 on the DEBOUNCE_CYCLES-th sample. The counter is cleared
  // on every exit, so it never exceeds CNT_LAST and never wraps.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;

    case (state_q)
      STABLE_LO: begin
        if (s_in) begin
          state_d = WAIT_HI;
          cnt_d   = CNT_ONE;
        end
      end

      WAIT_HI: begin
        if (!s_in) begin
          state_d = STABLE_LO;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_HI;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      STABLE_HI: begin
        if (!s_in) begin
          state_d = WAIT_LO;
          cnt_d   = CNT_ONE;
        end
      end

      WAIT_LO: begin
        if (s_in) begin
          state_d = STABLE_HI;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_LO;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d = STABLE_LO;
      end
    endcase

    // out is decoded from the next state and then registered. It therefore
    // changes on the same edge as the state, with no path from `in`.
    out_d = (state_d == STABLE_HI) || (state_d == WAIT_LO);
  end

endmodule
